pcie_tlp_mcast_demux: RTL and testbench

PCIE_TLP_MCAST_DEMUX -- requirements
Module: pcie_tlp_mcast_demux

---
 rtl/pcie_tlp_pkg.sv | 25 ++
 rtl/pcie_tlp_stat_cnt.sv | 22 ++
 rtl/pcie_tlp_mcast_demux.sv | 177 +++++++++++++++++
 tb/tb_pcie_tlp_mcast_demux.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tlp_pkg.sv
// Shared TLP field widths and drop classification for the multicast demux.
package pcie_tlp_pkg;

   localparam int TLP_HDR_W      = 128;
   localparam int TLP_BAR_ID_W   = 3;
   localparam int TLP_FUNC_NUM_W = 8;
   localparam int TLP_ERROR_W    = 4;

   typedef enum logic [1:0] {
      DROP_NONE,
      DROP_CMD,
      DROP_NOSEL
   } drop_reason_e;

   // An explicit drop command outranks an empty destination mask.
   function automatic drop_reason_e classify_drop(input logic cmd, input logic no_sel);
      if (cmd)
         return DROP_CMD;
      else if (no_sel)
         return DROP_NOSEL;
      else
         return DROP_NONE;
   endfunction

endpackage

// File: rtl/pcie_tlp_stat_cnt.sv
// Saturating event counter with synchronous clear; clear wins over a same-cycle increment.
module pcie_tlp_stat_cnt #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pcie_tlp_mcast_demux.sv
// PCIe TLP multicast demux: one output register stage fanning each beat to the mask latched at SOP.
// Statistics counters exist only when PCIE_TLP_DEMUX_STATS_EN is defined.
module pcie_tlp_mcast_demux
   import pcie_tlp_pkg::*;
#(
   parameter int PORTS          = 4,
   parameter int TLP_DATA_WIDTH = 256,
   parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH / 32,
   parameter int TLP_HDR_WIDTH  = 128,
   parameter int SEQ_NUM_WIDTH  = 6,
   parameter int STAT_WIDTH     = 32
) (
   input  logic                                 clk,
   input  logic                                 rst_n,

   input  logic [TLP_DATA_WIDTH-1:0]            in_tlp_data,
   input  logic [TLP_STRB_WIDTH-1:0]            in_tlp_strb,
   input  logic [TLP_HDR_WIDTH-1:0]             in_tlp_hdr,
   input  logic [SEQ_NUM_WIDTH-1:0]             in_tlp_seq,
   input  logic [TLP_BAR_ID_W-1:0]              in_tlp_bar_id,
   input  logic [TLP_FUNC_NUM_W-1:0]            in_tlp_func_num,
   input  logic [TLP_ERROR_W-1:0]               in_tlp_error,
   input  logic                                 in_tlp_valid,
   input  logic                                 in_tlp_sop,
   input  logic                                 in_tlp_eop,
   output logic                                 in_tlp_ready,

   output logic [PORTS*TLP_DATA_WIDTH-1:0]      out_tlp_data,
   output logic [PORTS*TLP_STRB_WIDTH-1:0]      out_tlp_strb,
   output logic [PORTS*TLP_HDR_WIDTH-1:0]       out_tlp_hdr,
   output logic [PORTS*SEQ_NUM_WIDTH-1:0]       out_tlp_seq,
   output logic [PORTS*TLP_BAR_ID_W-1:0]        out_tlp_bar_id,
   output logic [PORTS*TLP_FUNC_NUM_W-1:0]      out_tlp_func_num,
   output logic [PORTS*TLP_ERROR_W-1:0]         out_tlp_error,
   output logic [PORTS-1:0]                     out_tlp_valid,
   output logic [PORTS-1:0]                     out_tlp_sop,
   output logic [PORTS-1:0]                     out_tlp_eop,
   input  logic [PORTS-1:0]                     out_tlp_ready,

   output logic [TLP_HDR_WIDTH-1:0]             match_tlp_hdr,
   output logic [TLP_BAR_ID_W-1:0]              match_tlp_bar_id,
   output logic [TLP_FUNC_NUM_W-1:0]            match_tlp_func_num,

   input  logic                                 enable,
   input  logic                                 drop,
   input  logic [PORTS-1:0]                     select,

   output logic [PORTS*STAT_WIDTH-1:0]          stat_tlp_count,
   output logic [STAT_WIDTH-1:0]                stat_drop_count,
   input  logic                                 stat_clear
);

   if (TLP_HDR_WIDTH != TLP_HDR_W) begin : g_hdr_width_chk
      $fatal(1, "pcie_tlp_mcast_demux: TLP_HDR_WIDTH must be 128");
   end
   if (PORTS < 2 || PORTS > 16) begin : g_ports_chk
      $fatal(1, "pcie_tlp_mcast_demux: PORTS must be 2..16");
   end

   logic [PORTS-1:0]          out_valid_reg;
   logic                      frame_reg;
   logic [PORTS-1:0]          dest_mask_reg;
   logic                      drop_flag_reg;

   logic [TLP_DATA_WIDTH-1:0] data_reg;
   logic [TLP_STRB_WIDTH-1:0] strb_reg;
   logic [TLP_HDR_WIDTH-1:0]  hdr_reg;
   logic [SEQ_NUM_WIDTH-1:0]  seq_reg;
   logic [TLP_BAR_ID_W-1:0]   bar_id_reg;
   logic [TLP_FUNC_NUM_W-1:0] func_num_reg;
   logic [TLP_ERROR_W-1:0]    error_reg;
   logic                      sop_reg;
   logic                      eop_reg;

   logic                      ready_int;
   logic                      beat_acc;
   drop_reason_e              sop_reason;
   logic [PORTS-1:0]          eff_mask;
   logic                      eff_fwd;
   logic [PORTS-1:0]          load;

   // A held beat blocks the input until its port drains, so the shared data register never changes under it.
   assign ready_int    = enable && (&(~out_valid_reg | out_tlp_ready));
   assign in_tlp_ready = ready_int;
   assign beat_acc     = in_tlp_valid && ready_int;
   assign sop_reason   = classify_drop(drop, select == '0);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      eff_mask = dest_mask_reg;
      eff_fwd  = frame_reg && !drop_flag_reg;
      if (in_tlp_sop) begin
         eff_mask = select;
         eff_fwd  = (sop_reason == DROP_NONE);
      end
      load = '0;
      if (beat_acc && eff_fwd)
         load = eff_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= '0;
         frame_reg     <= 1'b0;
         dest_mask_reg <= '0;
         drop_flag_reg <= 1'b0;
      end else begin
         out_valid_reg <= load | (out_valid_reg & ~out_tlp_ready);
         if (beat_acc) begin
            if (in_tlp_sop) begin
               dest_mask_reg <= select;
               drop_flag_reg <= (sop_reason != DROP_NONE);
            end
            if (in_tlp_eop)
               frame_reg <= 1'b0;
            else if (in_tlp_sop)
               frame_reg <= 1'b1;
         end
      end
   end

   // NOTE: payload registers carry no reset; out_valid_reg alone qualifies them.
   always_ff @(posedge clk) begin
      if (beat_acc) begin
         data_reg     <= in_tlp_data;
         strb_reg     <= in_tlp_strb;
         hdr_reg      <= in_tlp_hdr;
         seq_reg      <= in_tlp_seq;
         bar_id_reg   <= in_tlp_bar_id;
         func_num_reg <= in_tlp_func_num;
         error_reg    <= in_tlp_error;
         sop_reg      <= in_tlp_sop;
         eop_reg      <= in_tlp_eop;
      end
   end

   assign out_tlp_data     = {PORTS{data_reg}};
   assign out_tlp_strb     = {PORTS{strb_reg}};
   assign out_tlp_hdr      = {PORTS{hdr_reg}};
   assign out_tlp_seq      = {PORTS{seq_reg}};
   assign out_tlp_bar_id   = {PORTS{bar_id_reg}};
   assign out_tlp_func_num = {PORTS{func_num_reg}};
   assign out_tlp_error    = {PORTS{error_reg}};
   assign out_tlp_sop      = {PORTS{sop_reg}};
   assign out_tlp_eop      = {PORTS{eop_reg}};
   assign out_tlp_valid    = out_valid_reg;

   assign match_tlp_hdr      = in_tlp_hdr;
   assign match_tlp_bar_id   = in_tlp_bar_id;
   assign match_tlp_func_num = in_tlp_func_num;

`ifdef PCIE_TLP_DEMUX_STATS_EN
   for (genvar p = 0; p < PORTS; p++) begin : g_tlp_cnt
      pcie_tlp_stat_cnt #(.WIDTH(STAT_WIDTH)) u_tlp_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (stat_clear),
         .inc   (load[p] && in_tlp_eop),
         .count (stat_tlp_count[p*STAT_WIDTH +: STAT_WIDTH])
      );
   end

   pcie_tlp_stat_cnt #(.WIDTH(STAT_WIDTH)) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (stat_clear),
      .inc   (beat_acc && in_tlp_sop && (sop_reason != DROP_NONE)),
      .count (stat_drop_count)
   );
`else
   logic unused_stat_clear;
   assign unused_stat_clear = stat_clear;
   assign stat_tlp_count    = '0;
   assign stat_drop_count   = '0;
`endif

endmodule

// File: tb/tb_pcie_tlp_mcast_demux.sv
// Randomized and directed bench for pcie_tlp_mcast_demux against a per-port pending-beat model.
module tb_pcie_tlp_mcast_demux;

   localparam int PORTS = 4;
   localparam int DW    = 64;
   localparam int SW    = DW / 32;
   localparam int HW    = 128;
   localparam int QW    = 6;
   localparam int STW   = 2;
   localparam int SAT   = (1 << STW) - 1;
`ifdef PCIE_TLP_DEMUX_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic [HW-1:0] hdr;
      logic [QW-1:0] seq;
      logic [2:0]    bar;
      logic [7:0]    func;
      logic [3:0]    err;
      logic          sop;
      logic          eop;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [DW-1:0]        in_tlp_data;
   logic [SW-1:0]        in_tlp_strb;
   logic [HW-1:0]        in_tlp_hdr;
   logic [QW-1:0]        in_tlp_seq;
   logic [2:0]           in_tlp_bar_id;
   logic [7:0]           in_tlp_func_num;
   logic [3:0]           in_tlp_error;
   logic                 in_tlp_valid, in_tlp_sop, in_tlp_eop, in_tlp_ready;
   logic [PORTS*DW-1:0]  out_tlp_data;
   logic [PORTS*SW-1:0]  out_tlp_strb;
   logic [PORTS*HW-1:0]  out_tlp_hdr;
   logic [PORTS*QW-1:0]  out_tlp_seq;
   logic [PORTS*3-1:0]   out_tlp_bar_id;
   logic [PORTS*8-1:0]   out_tlp_func_num;
   logic [PORTS*4-1:0]   out_tlp_error;
   logic [PORTS-1:0]     out_tlp_valid, out_tlp_sop, out_tlp_eop, out_tlp_ready;
   logic [HW-1:0]        match_tlp_hdr;
   logic [2:0]           match_tlp_bar_id;
   logic [7:0]           match_tlp_func_num;
   logic                 enable, drop, stat_clear;
   logic [PORTS-1:0]     select;
   logic [PORTS*STW-1:0] stat_tlp_count;
   logic [STW-1:0]       stat_drop_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pcie_tlp_mcast_demux #(
      .PORTS(PORTS), .TLP_DATA_WIDTH(DW), .TLP_STRB_WIDTH(SW), .TLP_HDR_WIDTH(HW),
      .SEQ_NUM_WIDTH(QW), .STAT_WIDTH(STW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_tlp_data(in_tlp_data), .in_tlp_strb(in_tlp_strb), .in_tlp_hdr(in_tlp_hdr),
      .in_tlp_seq(in_tlp_seq), .in_tlp_bar_id(in_tlp_bar_id), .in_tlp_func_num(in_tlp_func_num),
      .in_tlp_error(in_tlp_error), .in_tlp_valid(in_tlp_valid), .in_tlp_sop(in_tlp_sop),
      .in_tlp_eop(in_tlp_eop), .in_tlp_ready(in_tlp_ready),
      .out_tlp_data(out_tlp_data), .out_tlp_strb(out_tlp_strb), .out_tlp_hdr(out_tlp_hdr),
      .out_tlp_seq(out_tlp_seq), .out_tlp_bar_id(out_tlp_bar_id), .out_tlp_func_num(out_tlp_func_num),
      .out_tlp_error(out_tlp_error), .out_tlp_valid(out_tlp_valid), .out_tlp_sop(out_tlp_sop),
      .out_tlp_eop(out_tlp_eop), .out_tlp_ready(out_tlp_ready),
      .match_tlp_hdr(match_tlp_hdr), .match_tlp_bar_id(match_tlp_bar_id),
      .match_tlp_func_num(match_tlp_func_num),
      .enable(enable), .drop(drop), .select(select),
      .stat_tlp_count(stat_tlp_count), .stat_drop_count(stat_drop_count), .stat_clear(stat_clear)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model: one pending beat per port ----------------
   bit          m_pend[PORTS];
   bit          m_frame;
   bit [PORTS-1:0] m_mask;
   bit          m_drop;
   int          m_tlp[PORTS];
   int          m_drp;
   beat_t       m_last;
   bit          m_known = 1'b0;

   bit          n_pend[PORTS];
   bit          n_frame;
   bit [PORTS-1:0] n_mask;
   bit          n_drop;
   int          n_tlp[PORTS];
   int          n_drp;
   beat_t       n_last;
   bit          n_known;
   bit          exp_ready;
   bit          m_acc;

   function automatic int sat(input int x);
      return (x > SAT) ? SAT : x;
   endfunction

   always_comb begin
      n_pend  = m_pend;
      n_frame = m_frame;
      n_mask  = m_mask;
      n_drop  = m_drop;
      n_tlp   = m_tlp;
      n_drp   = m_drp;
      n_last  = m_last;
      n_known = m_known;
      exp_ready = enable;
      for (int p = 0; p < PORTS; p++)
         if (m_pend[p] && !out_tlp_ready[p]) exp_ready = 1'b0;
      m_acc = in_tlp_valid && exp_ready;
      for (int p = 0; p < PORTS; p++)
         if (out_tlp_ready[p]) n_pend[p] = 1'b0;
      if (m_acc) begin
         n_last  = '{in_tlp_data, in_tlp_strb, in_tlp_hdr, in_tlp_seq, in_tlp_bar_id,
                     in_tlp_func_num, in_tlp_error, in_tlp_sop, in_tlp_eop};
         n_known = 1'b1;
         if (in_tlp_sop) begin
            n_frame = 1'b1;
            n_mask  = select;
            n_drop  = drop || (select == '0);
            if (n_drop) n_drp = sat(n_drp + 1);
         end
         if (n_frame && !n_drop)
            for (int p = 0; p < PORTS; p++)
               if (n_mask[p]) begin
                  n_pend[p] = 1'b1;
                  if (in_tlp_eop) n_tlp[p] = sat(n_tlp[p] + 1);
               end
         if (in_tlp_eop) n_frame = 1'b0;
      end
      if (stat_clear) begin
         n_drp = 0;
         for (int p = 0; p < PORTS; p++) n_tlp[p] = 0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend  <= '{default: 1'b0};
         m_frame <= 1'b0;
         m_mask  <= '0;
         m_drop  <= 1'b0;
         m_tlp   <= '{default: 0};
         m_drp   <= 0;
      end else begin
         m_pend  <= n_pend;
         m_frame <= n_frame;
         m_mask  <= n_mask;
         m_drop  <= n_drop;
         m_tlp   <= n_tlp;
         m_drp   <= n_drp;
         m_last  <= n_last;
         m_known <= n_known;
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   int hs_cnt[PORTS] = '{default: 0};

   initial forever begin
      @(negedge clk);
      for (int p = 0; p < PORTS; p++)
         if (out_tlp_valid[p] === 1'b1 && out_tlp_ready[p] === 1'b1) hs_cnt[p]++;
      check("in_ready", in_tlp_ready, exp_ready);
      for (int p = 0; p < PORTS; p++) begin
         check($sformatf("valid[%0d]", p), out_tlp_valid[p], m_pend[p]);
         if (m_known) begin
            beat_t got;
            got = '{out_tlp_data[p*DW +: DW], out_tlp_strb[p*SW +: SW], out_tlp_hdr[p*HW +: HW],
                    out_tlp_seq[p*QW +: QW], out_tlp_bar_id[p*3 +: 3], out_tlp_func_num[p*8 +: 8],
                    out_tlp_error[p*4 +: 4], out_tlp_sop[p], out_tlp_eop[p]};
            check($sformatf("beat[%0d]", p), got, m_last);
         end
         check($sformatf("stat_tlp[%0d]", p), stat_tlp_count[p*STW +: STW], STATS_ON ? m_tlp[p] : 0);
      end
      check("stat_drop", stat_drop_count, STATS_ON ? m_drp : 0);
      check("match_hdr", {match_tlp_hdr, match_tlp_bar_id, match_tlp_func_num},
            {in_tlp_hdr, in_tlp_bar_id, in_tlp_func_num});
   end

   // ---------------- stimulus helpers ----------------
   int hs_base[PORTS];

   task automatic hs_mark();
      for (int p = 0; p < PORTS; p++) hs_base[p] = hs_cnt[p];
   endtask

   function automatic int hs_delta(input int p);
      return hs_cnt[p] - hs_base[p];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input bit sop, input bit eop, input logic [PORTS-1:0] sel, input bit drp);
      in_tlp_valid    = 1'b1;
      in_tlp_sop      = sop;
      in_tlp_eop      = eop;
      select          = sel;
      drop            = drp;
      in_tlp_data     = {$urandom, $urandom};
      in_tlp_strb     = SW'($urandom);
      in_tlp_hdr      = {$urandom, $urandom, $urandom, $urandom};
      in_tlp_seq      = QW'($urandom);
      in_tlp_bar_id   = 3'($urandom);
      in_tlp_func_num = 8'($urandom);
      in_tlp_error    = 4'($urandom);
   endtask

   // Returns once the driven beat has been taken at a clock edge (inputs then free to change).
   task automatic wait_accept(output int waits);
      waits = 0;
      forever begin
         @(negedge clk);
         if (in_tlp_ready === 1'b1) break;
         waits++;
         if (waits > 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got no in_tlp_ready expected ready within 200 cycles");
            break;
         end
      end
      tick();
   endtask

   task automatic send_tlp(input int nbeats, input logic [PORTS-1:0] sel, input bit drp, output int waits);
      int w;
      waits = 0;
      for (int b = 0; b < nbeats; b++) begin
         drive_beat(b == 0, b == nbeats - 1, sel, drp);
         wait_accept(w);
         waits += w;
      end
      in_tlp_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int w;
      logic [DW-1:0] held;
      int rem;
      bit acc;

      in_tlp_valid = 1'b0; in_tlp_sop = 1'b0; in_tlp_eop = 1'b0;
      drive_beat(1'b0, 1'b0, '0, 1'b0);
      in_tlp_valid  = 1'b0;
      enable        = 1'b1;
      out_tlp_ready = '1;
      stat_clear    = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_valid", out_tlp_valid, 4'b0000);
      check("reset_stats", {stat_tlp_count, stat_drop_count}, '0);
      rst_n = 1'b1;
      tick();

      // Multicast 3-beat TLP to ports 0 and 2.
      pulse_clear();
      hs_mark();
      send_tlp(3, 4'b0101, 1'b0, w);
      repeat (3) tick();
      check("mc_p0_beats", hs_delta(0), 3);
      check("mc_p1_beats", hs_delta(1), 0);
      check("mc_p2_beats", hs_delta(2), 3);
      check("mc_p3_beats", hs_delta(3), 0);
      check("mc_stat_p0", stat_tlp_count[0 +: STW], STATS_ON ? 1 : 0);
      check("mc_stat_p2", stat_tlp_count[2*STW +: STW], STATS_ON ? 1 : 0);
      check("mc_stat_p1", stat_tlp_count[1*STW +: STW], 0);

      // Empty select at SOP drops the whole TLP without stalling.
      pulse_clear();
      hs_mark();
      send_tlp(2, 4'b0000, 1'b0, w);
      repeat (3) tick();
      check("nosel_waits", w, 0);
      check("nosel_beats", hs_delta(0) + hs_delta(1) + hs_delta(2) + hs_delta(3), 0);
      check("nosel_drop_cnt", stat_drop_count, STATS_ON ? 1 : 0);

      // Port 1 back-pressure holds the input and the port-1 beat.
      hs_mark();
      out_tlp_ready = 4'b0001;
      drive_beat(1'b1, 1'b0, 4'b0011, 1'b0);
      wait_accept(w);
      drive_beat(1'b0, 1'b1, 4'b1100, 1'b0);
      @(negedge clk);
      held = out_tlp_data[DW +: DW];
      for (int c = 0; c < 5; c++) begin
         check("bp_in_ready", in_tlp_ready, 1'b0);
         check("bp_p1_valid", out_tlp_valid[1], 1'b1);
         check("bp_p1_data", out_tlp_data[DW +: DW], held);
         tick();
         @(negedge clk);
      end
      tick();
      out_tlp_ready = '1;
      @(negedge clk);
      check("bp_release_ready", in_tlp_ready, 1'b1);
      tick();
      in_tlp_valid = 1'b0;
      repeat (3) tick();
      check("bp_p0_beats", hs_delta(0), 2);
      check("bp_p1_beats", hs_delta(1), 2);
      check("bp_p23_beats", hs_delta(2) + hs_delta(3), 0);

      // Orphan EOP is discarded; SOP inside a frame retargets to its own mask.
      hs_mark();
      drive_beat(1'b0, 1'b1, 4'b1111, 1'b0);
      wait_accept(w);
      drive_beat(1'b1, 1'b0, 4'b0001, 1'b0);
      wait_accept(w);
      drive_beat(1'b1, 1'b1, 4'b0100, 1'b0);
      wait_accept(w);
      in_tlp_valid = 1'b0;
      repeat (3) tick();
      check("orph_p0_beats", hs_delta(0), 1);
      check("orph_p2_beats", hs_delta(2), 1);
      check("orph_p13_beats", hs_delta(1) + hs_delta(3), 0);

      // Asynchronous reset after beat 1 of a 4-beat TLP.
      out_tlp_ready = '0;
      drive_beat(1'b1, 1'b0, 4'b1111, 1'b0);
      wait_accept(w);
      in_tlp_valid = 1'b0;
      @(negedge clk);
      check("rst_pre_valid", out_tlp_valid, 4'b1111);
      #2 rst_n = 1'b0;
      #1 check("rst_async_valid", out_tlp_valid, 4'b0000);
      #1 rst_n = 1'b1;
      tick();
      out_tlp_ready = '1;
      hs_mark();
      for (int b = 0; b < 3; b++) begin
         drive_beat(1'b0, b == 2, 4'b1111, 1'b0);
         wait_accept(w);
      end
      in_tlp_valid = 1'b0;
      repeat (3) tick();
      check("rst_discard_beats", hs_delta(0) + hs_delta(1) + hs_delta(2) + hs_delta(3), 0);
      check("rst_stats", {stat_tlp_count, stat_drop_count}, '0);

      // Saturation of a 2-bit counter.
      pulse_clear();
      for (int t = 0; t < 5; t++) send_tlp(1, 4'b0001, 1'b0, w);
      repeat (2) tick();
      check("sat_p0", stat_tlp_count[0 +: STW], STATS_ON ? 3 : 0);
      pulse_clear();
      @(negedge clk);
      check("sat_cleared", stat_tlp_count[0 +: STW], 0);

      // Randomized traffic checked cycle by cycle against the model.
      rem = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         acc = in_tlp_valid && in_tlp_ready;
         tick();
         for (int p = 0; p < PORTS; p++) out_tlp_ready[p] = ($urandom % 4) != 0;
         enable     = ($urandom % 8) != 0;
         stat_clear = ($urandom % 50) == 0;
         if (acc || !in_tlp_valid) begin
            if ($urandom % 4 == 0) begin
               in_tlp_valid = 1'b0;
            end else begin
               bit s, e;
               logic [PORTS-1:0] sel;
               sel = ($urandom % 8 == 0) ? '0 : PORTS'($urandom);
               e = 1'b0;
               if (rem == 0 && ($urandom % 12) == 0) begin
                  s = 1'b0;
                  e = ($urandom % 2) == 1;
               end else begin
                  s = (rem == 0) || (($urandom % 16) == 0);
                  if (s) rem = 1 + ($urandom % 4);
                  e = (rem == 1);
                  rem--;
               end
               drive_beat(s, e, sel, ($urandom % 10) == 0);
            end
         end
      end
      in_tlp_valid  = 1'b0;
      enable        = 1'b1;
      out_tlp_ready = '1;
      stat_clear    = 1'b0;
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
